// File: rtl/swc_page_alloc_arbiter.sv
// swc_page_alloc_arbiter
//   Shares one single-port page allocator core among g_num_ports requesters.
//   Round-robin grant, one operation in flight at the core at a time; the
//   completion pulse and allocated page go back to the granted requester only.
//
// Ports
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   rq_alloc_i/free_i/force_free_i/set_usecnt_i
//                            per-port request levels, held until rq_done_o
//   rq_pgaddr_i, rq_usecnt_i per-port page address / use count (packed, port 0 in LSBs)
//   rq_done_o                one-cycle completion pulse to the granted port
//   rq_pgaddr_alloc_o        page returned by the last completed alloc
//   rq_nomem_o               core_nomem_i registered one cycle
//   core_*_o                 operation strobes, page address and use count to the core
//   core_done_i, core_pgaddr_alloc_i, core_nomem_i   core responses
module swc_page_alloc_arbiter #(
  parameter int g_num_ports       = 8,
  parameter int g_page_addr_width = 10,
  parameter int g_usecnt_width    = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_n_i,
  input  logic [g_num_ports-1:0]                     rq_alloc_i,
  input  logic [g_num_ports-1:0]                     rq_free_i,
  input  logic [g_num_ports-1:0]                     rq_force_free_i,
  input  logic [g_num_ports-1:0]                     rq_set_usecnt_i,
  input  logic [g_num_ports*g_page_addr_width-1:0]   rq_pgaddr_i,
  input  logic [g_num_ports*g_usecnt_width-1:0]      rq_usecnt_i,
  output logic [g_num_ports-1:0]                     rq_done_o,
  output logic [g_page_addr_width-1:0]               rq_pgaddr_alloc_o,
  output logic                                       rq_nomem_o,
  output logic                                       core_alloc_o,
  output logic                                       core_free_o,
  output logic                                       core_force_free_o,
  output logic                                       core_set_usecnt_o,
  output logic [g_page_addr_width-1:0]               core_pgaddr_o,
  output logic [g_usecnt_width-1:0]                  core_usecnt_o,
  input  logic                                       core_done_i,
  input  logic [g_page_addr_width-1:0]               core_pgaddr_alloc_i,
  input  logic                                       core_nomem_i
);

  localparam int N  = g_num_ports;
  localparam int PW = g_page_addr_width;
  localparam int UW = g_usecnt_width;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RELEASE} state_t;
  typedef enum logic [1:0] {OP_FORCE_FREE, OP_FREE, OP_SET_USECNT, OP_ALLOC} op_t;

  state_t          state_reg;
  op_t             op_reg;
  logic [IW-1:0]   rr_reg;
  logic [IW-1:0]   grant_reg;
  logic [PW-1:0]   pgaddr_reg;
  logic [UW-1:0]   usecnt_reg;
  logic [PW-1:0]   pgaddr_alloc_reg;
  logic [N-1:0]    done_reg;
  logic            nomem_reg;
  logic            alloc_reg;
  logic            free_reg;
  logic            force_free_reg;
  logic            set_usecnt_reg;

  logic [N-1:0]    pending;
  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  op_t             gnt_op;

  // Alloc requests are masked while the core reports no free pages, so a
  // starved alloc never blocks other ports' frees.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pending
      assign pending[gi] = rq_force_free_i[gi] | rq_free_i[gi] | rq_set_usecnt_i[gi]
                         | (rq_alloc_i[gi] & ~nomem_reg);
    end
  endgenerate

  // First pending port at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(rr_reg) + k) % N);
      if (!gnt_found && pending[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // One operation per grant; the lower-priority bits stay pending.
  always_comb begin
    gnt_op = OP_ALLOC;
    if (rq_force_free_i[gnt_idx])      gnt_op = OP_FORCE_FREE;
    else if (rq_free_i[gnt_idx])       gnt_op = OP_FREE;
    else if (rq_set_usecnt_i[gnt_idx]) gnt_op = OP_SET_USECNT;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg        <= ST_IDLE;
      op_reg           <= OP_ALLOC;
      rr_reg           <= '0;
      grant_reg        <= '0;
      pgaddr_reg       <= '0;
      usecnt_reg       <= '0;
      pgaddr_alloc_reg <= '0;
      done_reg         <= '0;
      nomem_reg        <= 1'b0;
      alloc_reg        <= 1'b0;
      free_reg         <= 1'b0;
      force_free_reg   <= 1'b0;
      set_usecnt_reg   <= 1'b0;
    end else begin
      nomem_reg <= core_nomem_i;
      case (state_reg)
        ST_IDLE: begin
          if (gnt_found) begin
            grant_reg      <= gnt_idx;
            op_reg         <= gnt_op;
            pgaddr_reg     <= rq_pgaddr_i[gnt_idx*PW +: PW];
            usecnt_reg     <= rq_usecnt_i[gnt_idx*UW +: UW];
            force_free_reg <= (gnt_op == OP_FORCE_FREE);
            free_reg       <= (gnt_op == OP_FREE);
            set_usecnt_reg <= (gnt_op == OP_SET_USECNT);
            alloc_reg      <= (gnt_op == OP_ALLOC);
            state_reg      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (core_done_i) begin
            force_free_reg <= 1'b0;
            free_reg       <= 1'b0;
            set_usecnt_reg <= 1'b0;
            alloc_reg      <= 1'b0;
            done_reg       <= {{(N-1){1'b0}}, 1'b1} << grant_reg;
            if (op_reg == OP_ALLOC) pgaddr_alloc_reg <= core_pgaddr_alloc_i;
            state_reg      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // The requester drops its bit on this edge, so IDLE never sees
          // the just-finished request.
          done_reg  <= '0;
          rr_reg    <= (grant_reg == IW'(N - 1)) ? '0 : grant_reg + 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rq_done_o         = done_reg;
  assign rq_pgaddr_alloc_o = pgaddr_alloc_reg;
  assign rq_nomem_o        = nomem_reg;
  assign core_alloc_o      = alloc_reg;
  assign core_free_o       = free_reg;
  assign core_force_free_o = force_free_reg;
  assign core_set_usecnt_o = set_usecnt_reg;
  assign core_pgaddr_o     = pgaddr_reg;
  assign core_usecnt_o     = usecnt_reg;

endmodule

// File: tb/tb_swc_page_alloc_arbiter.sv
// tb_swc_page_alloc_arbiter
//   Directed scenarios plus a randomised mix against a transaction-level
//   reference (grant order, latched operands, completion routing) and a
//   page-table model of the allocator core.
module tb_swc_page_alloc_arbiter;

  localparam int N  = 8;
  localparam int PW = 10;
  localparam int UW = 4;
  localparam int OP_FF = 0, OP_FREE = 1, OP_SET = 2, OP_ALLOC = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      rq_alloc = '0, rq_free = '0, rq_ff = '0, rq_set = '0;
  logic [N*PW-1:0]   rq_pgaddr = '0;
  logic [N*UW-1:0]   rq_usecnt = '0;
  logic [N-1:0]      rq_done_o;
  logic [PW-1:0]     rq_pgaddr_alloc_o;
  logic              rq_nomem_o;
  logic              core_alloc_o, core_free_o, core_force_free_o, core_set_usecnt_o;
  logic [PW-1:0]     core_pgaddr_o;
  logic [UW-1:0]     core_usecnt_o;
  logic              core_done = 1'b0;
  logic [PW-1:0]     core_pgaddr_alloc = '0;
  logic              core_nomem = 1'b0;

  always #5 clk = ~clk;

  swc_page_alloc_arbiter #(.g_num_ports(N), .g_page_addr_width(PW), .g_usecnt_width(UW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rq_alloc_i(rq_alloc), .rq_free_i(rq_free), .rq_force_free_i(rq_ff), .rq_set_usecnt_i(rq_set),
    .rq_pgaddr_i(rq_pgaddr), .rq_usecnt_i(rq_usecnt),
    .rq_done_o(rq_done_o), .rq_pgaddr_alloc_o(rq_pgaddr_alloc_o), .rq_nomem_o(rq_nomem_o),
    .core_alloc_o(core_alloc_o), .core_free_o(core_free_o), .core_force_free_o(core_force_free_o),
    .core_set_usecnt_o(core_set_usecnt_o), .core_pgaddr_o(core_pgaddr_o), .core_usecnt_o(core_usecnt_o),
    .core_done_i(core_done), .core_pgaddr_alloc_i(core_pgaddr_alloc), .core_nomem_i(core_nomem)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- core model / page table ----------------
  int  core_cnt = 0;
  int  core_lat = 1;
  bit  track = 1'b0;
  bit  used [0:(1<<PW)-1];
  int  free_q[$];
  int  done_log[$];
  int  owned[N][$];

  task automatic core_action(input logic [3:0] sop, input int pg);
    // sop = {force_free, free, set_usecnt, alloc}
    if (sop[0]) begin
      int np;
      np = free_q.pop_front();
      core_pgaddr_alloc = PW'(np);
      if (track) begin
        chk("alloc_page_unused", 64'(used[np]), 64'd0);
        used[np] = 1'b1;
      end
    end else if (sop[3] || sop[2]) begin
      if (track) begin
        chk("no_double_free", 64'(used[pg]), 64'd1);
        used[pg] = 1'b0;
        free_q.push_back(pg);
      end
    end else if (sop[1]) begin
      if (track) chk("set_usecnt_on_used", 64'(used[pg]), 64'd1);
    end
    if (track) core_lat = $urandom_range(1, 3);
  endtask

  // One clock: requesters drop serviced bits on the edge ending the done
  // pulse, and the core answers a strobe it has seen for core_lat edges.
  task automatic tick();
    logic [N-1:0]  d;
    logic [3:0]    sop;
    logic [PW-1:0] pa;
    int            cpg;
    int            op;
    d   = rq_done_o;
    sop = {core_force_free_o, core_free_o, core_set_usecnt_o, core_alloc_o};
    pa  = rq_pgaddr_alloc_o;
    cpg = int'(core_pgaddr_o);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        if (rq_ff[i])       begin op = OP_FF;    rq_ff[i]    = 1'b0; end
        else if (rq_free[i]) begin op = OP_FREE; rq_free[i]  = 1'b0; end
        else if (rq_set[i])  begin op = OP_SET;  rq_set[i]   = 1'b0; end
        else                 begin op = OP_ALLOC; rq_alloc[i] = 1'b0; end
        done_log.push_back(i * 4 + op);
        if (track && op == OP_ALLOC) owned[i].push_back(int'(pa));
      end
    end
    if (!rst_n) begin
      core_done = 1'b0;
      core_cnt  = 0;
    end else if (core_done) begin
      core_done = 1'b0;
    end else if (|sop) begin
      core_cnt++;
      if (core_cnt >= core_lat) begin
        core_cnt  = 0;
        core_done = 1'b1;
        core_action(sop, cpg);
      end
    end
  endtask

  task automatic set_req(input int port, input int op, input int pg, input int uc);
    case (op)
      OP_FF:   rq_ff[port]    = 1'b1;
      OP_FREE: rq_free[port]  = 1'b1;
      OP_SET:  rq_set[port]   = 1'b1;
      default: rq_alloc[port] = 1'b1;
    endcase
    if (op != OP_ALLOC) rq_pgaddr[port*PW +: PW] = PW'(pg);
    if (op == OP_SET || op == OP_ALLOC) rq_usecnt[port*UW +: UW] = UW'(uc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq_alloc = '0; rq_free = '0; rq_ff = '0; rq_set = '0;
    core_nomem = 1'b0;
    core_lat = 1;
    tick();
    tick();
    rst_n = 1'b1;
    done_log.delete();
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((|{rq_alloc, rq_free, rq_ff, rq_set}) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_within_bound", 64'(n < max_cycles), 64'd1);
  endtask

  task automatic chk_log(input int idx, input int port, input int op);
    int act;
    act = (idx < done_log.size()) ? done_log[idx] : -1;
    chk($sformatf("completion_%0d(port*4+op)", idx), 64'(act), 64'(port * 4 + op));
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // Transaction view: an operation is either in flight (busy), being
  // acknowledged (done_port) or absent; grants follow round-robin order.
  int m_busy, m_port, m_op, m_pg, m_uc, m_done_port, m_rr, m_alloc_page, m_nomem;
  logic [3:0]   exp_str;
  logic [N-1:0] exp_done;
  logic [N-1:0] one_n;

  initial begin
    one_n = 1;
    m_busy = 0; m_port = 0; m_op = 0; m_pg = 0; m_uc = 0;
    m_done_port = -1; m_rr = 0; m_alloc_page = 0; m_nomem = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_done_port = -1; m_rr = 0; m_alloc_page = 0; m_nomem = 0;
      end
      exp_str  = (m_busy != 0) ? (4'b1000 >> m_op) : 4'b0000;
      exp_done = (m_done_port >= 0) ? (one_n << m_done_port) : '0;
      chk("core_strobes{ff,free,set,alloc}",
          64'({core_force_free_o, core_free_o, core_set_usecnt_o, core_alloc_o}), 64'(exp_str));
      if (m_busy != 0 && m_op != OP_ALLOC) chk("core_pgaddr", 64'(core_pgaddr_o), 64'(m_pg));
      if (m_busy != 0 && (m_op == OP_SET || m_op == OP_ALLOC))
        chk("core_usecnt", 64'(core_usecnt_o), 64'(m_uc));
      chk("rq_done", 64'(rq_done_o), 64'(exp_done));
      chk("rq_pgaddr_alloc", 64'(rq_pgaddr_alloc_o), 64'(m_alloc_page));
      chk("rq_nomem", 64'(rq_nomem_o), 64'(m_nomem));
      if (rst_n) begin
        if (m_done_port >= 0) begin
          m_rr = (m_done_port + 1) % N;
          m_done_port = -1;
        end else if (m_busy != 0) begin
          if (core_done) begin
            m_busy = 0;
            m_done_port = m_port;
            if (m_op == OP_ALLOC) m_alloc_page = int'(core_pgaddr_alloc);
          end
        end else begin
          for (int k = 0; k < N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (m_busy == 0 && (rq_ff[p] || rq_free[p] || rq_set[p] || (rq_alloc[p] && m_nomem == 0))) begin
              m_busy = 1;
              m_port = p;
              m_op   = rq_ff[p] ? OP_FF : rq_free[p] ? OP_FREE : rq_set[p] ? OP_SET : OP_ALLOC;
              m_pg   = int'(rq_pgaddr[p*PW +: PW]);
              m_uc   = int'(rq_usecnt[p*UW +: UW]);
            end
          end
        end
        m_nomem = int'(core_nomem);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, max_wait, used_cnt, owned_sum;
    int waitc[N];
    for (int p = 5; p < (1 << PW); p++) free_q.push_back(p);

    // Reset state
    tick();
    chk("reset_strobes", 64'({core_force_free_o, core_free_o, core_set_usecnt_o, core_alloc_o}), 64'd0);
    chk("reset_done", 64'(rq_done_o), 64'd0);
    chk("reset_nomem", 64'(rq_nomem_o), 64'd0);
    do_reset();

    // 1: port 3 alloc, 1-cycle core, page 0x05
    set_req(3, OP_ALLOC, 0, 2);
    tick();
    chk("t1_alloc_strobe", 64'(core_alloc_o), 64'd1);
    chk("t1_usecnt", 64'(core_usecnt_o), 64'd2);
    n = 1;
    while (!rq_done_o[3] && n < 20) begin tick(); n++; end
    chk("t1_latency_cycles", 64'(n), 64'd3);
    chk("t1_pgaddr_alloc", 64'(rq_pgaddr_alloc_o), 64'h05);
    tick();
    chk("t1_done_one_cycle", 64'(rq_done_o), 64'd0);
    chk_log(0, 3, OP_ALLOC);

    // 2: ports 0,2,5 together, then 5 and 0 with rr=6 wrapping
    do_reset();
    set_req(0, OP_ALLOC, 0, 1); set_req(2, OP_ALLOC, 0, 1); set_req(5, OP_ALLOC, 0, 1);
    wait_idle(60);
    chk_log(0, 0, OP_ALLOC); chk_log(1, 2, OP_ALLOC); chk_log(2, 5, OP_ALLOC);
    set_req(5, OP_ALLOC, 0, 3); set_req(0, OP_ALLOC, 0, 3);
    wait_idle(60);
    chk_log(3, 0, OP_ALLOC); chk_log(4, 5, OP_ALLOC);

    // 3: port 1 free + alloc together -> free first
    do_reset();
    set_req(1, OP_FREE, 'h10, 0); set_req(1, OP_ALLOC, 0, 1);
    tick();
    chk("t3_free_first", 64'({core_free_o, core_alloc_o}), 64'b10);
    chk("t3_free_pgaddr", 64'(core_pgaddr_o), 64'h10);
    wait_idle(60);
    chk_log(0, 1, OP_FREE); chk_log(1, 1, OP_ALLOC);

    // 4: no_mem holds port 0 alloc, port 1 free still served
    do_reset();
    core_nomem = 1'b1;
    tick(); tick();
    chk("t4_nomem_reg", 64'(rq_nomem_o), 64'd1);
    set_req(0, OP_ALLOC, 0, 1); set_req(1, OP_FREE, 'h22, 0);
    n = 0;
    while (done_log.size() < 1 && n < 20) begin tick(); n++; end
    repeat (5) tick();
    chk("t4_only_free_done", 64'(done_log.size()), 64'd1);
    chk_log(0, 1, OP_FREE);
    core_nomem = 1'b0;
    wait_idle(60);
    chk_log(1, 0, OP_ALLOC);

    // 5: async reset in the middle of a force_free
    do_reset();
    core_lat = 4;
    set_req(2, OP_FF, 'h33, 0);
    tick(); tick();
    chk("t5_ff_strobe_before_reset", 64'(core_force_free_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_strobes_async_clear",
        64'({core_force_free_o, core_free_o, core_set_usecnt_o, core_alloc_o}), 64'd0);
    chk("t5_done_async_clear", 64'(rq_done_o), 64'd0);
    set_req(0, OP_FREE, 'h44, 0);
    tick(); tick();
    rst_n = 1'b1;
    core_lat = 1;
    wait_idle(60);
    chk_log(0, 0, OP_FREE); chk_log(1, 2, OP_FF);

    // 6: random mix on all ports against a page table
    do_reset();
    free_q.delete();
    for (int p = 0; p < (1 << PW); p++) begin free_q.push_back(p); used[p] = 1'b0; end
    for (int i = 0; i < N; i++) begin owned[i].delete(); waitc[i] = 0; end
    track = 1'b1;
    max_wait = 0;
    repeat (1500) begin
      tick();
      core_nomem = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        if (rq_alloc[i] | rq_free[i] | rq_ff[i] | rq_set[i]) begin
          waitc[i]++;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end else begin
          waitc[i] = 0;
          if ($urandom_range(0, 3) == 0) begin
            int r, k, pg;
            r = $urandom_range(0, 3);
            if (owned[i].size() == 0 || (r == 0 && owned[i].size() < 3)) begin
              set_req(i, OP_ALLOC, 0, $urandom_range(1, 15));
            end else if (r == 1 || r == 2) begin
              k  = $urandom_range(0, owned[i].size() - 1);
              pg = owned[i][k];
              owned[i].delete(k);
              set_req(i, (r == 1) ? OP_FREE : OP_FF, pg, 0);
            end else begin
              set_req(i, OP_SET, owned[i][0], $urandom_range(1, 15));
            end
          end
        end
      end
    end
    core_nomem = 1'b0;
    wait_idle(300);
    used_cnt = 0;
    owned_sum = 0;
    for (int p = 0; p < (1 << PW); p++) used_cnt += int'(used[p]);
    for (int i = 0; i < N; i++) owned_sum += owned[i].size();
    chk("t6_page_count", 64'(used_cnt), 64'(owned_sum));
    chk("t6_no_starvation", 64'(max_wait < 150), 64'd1);
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
